// File: rtl/hazard_ctrl_if.sv
// Hazard sequencer bundle: hazard sources from ID/EX/memories in, pipeline-register
// enables, flushes and status out. Pure wiring, no latency, no backpressure of its own.
interface hazard_ctrl_if #(
    parameter int REGW = 3,
    parameter int CNTW = 4
);
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_read1;
    logic            id_read2;
    logic [REGW-1:0] ex_rd;
    logic            ex_mem_read;
    logic            redirect;
    logic            halt_id;
    logic            imem_stall;
    logic            dmem_stall;

    logic            pc_w_en;
    logic            if_id_w_en;
    logic            id_ex_w_en;
    logic            ex_mem_w_en;
    logic            mem_wb_w_en;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            halted;
    logic [CNTW-1:0] stall_cnt;
    logic            err;

    modport master (
        output id_rs, id_rt, id_read1, id_read2, ex_rd, ex_mem_read,
               redirect, halt_id, imem_stall, dmem_stall,
        input  pc_w_en, if_id_w_en, id_ex_w_en, ex_mem_w_en, mem_wb_w_en,
               if_id_flush, id_ex_flush, halted, stall_cnt, err
    );

    modport slave (
        input  id_rs, id_rt, id_read1, id_read2, ex_rd, ex_mem_read,
               redirect, halt_id, imem_stall, dmem_stall,
        output pc_w_en, if_id_w_en, id_ex_w_en, ex_mem_w_en, mem_wb_w_en,
               if_id_flush, id_ex_flush, halted, stall_cnt, err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: combinational enables/flushes from state+hazards (0 cycles),
// dmem_stall freezes everything; load-use, imem and halt drain stall the front end only.
module hazard_ctrl #(
    parameter int REGW      = 3,
    parameter int MAX_STALL = 15,
    parameter int CNTW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DRAIN   = 2'b01,
        HALTED  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_SAT = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_LIM = CNTW'(MAX_STALL);

    state_t          state_q, state_d;
    logic [1:0]      drain_q, drain_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic            err_q, err_d;

    logic [REGW-1:0] rs, rt, rd;
    logic            load_use;
    logic            pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic            if_id_fl, id_ex_fl, halted_o;

    assign rs = bus.id_rs;
    assign rt = bus.id_rt;
    assign rd = bus.ex_rd;
    assign load_use = bus.ex_mem_read &
                      ((bus.id_read1 & (rs == rd)) | (bus.id_read2 & (rt == rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            drain_q <= 2'd0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (!bus.dmem_stall && !bus.redirect && !load_use &&
                    !bus.imem_stall && bus.halt_id) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end
            end
            DRAIN: begin
                if (bus.dmem_stall) begin
                    drain_d = drain_q;
                end else if (bus.redirect) begin
                    // Redirect here comes from a branch older than the HALT: resume.
                    state_d = RUN;
                    drain_d = 2'd0;
                end else begin
                    drain_d = drain_q + 2'd1;
                    if (drain_q == 2'd2) state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        mem_wb_we = 1'b0;
        if_id_fl  = 1'b0;
        id_ex_fl  = 1'b0;
        halted_o  = 1'b0;
        if (!rst) begin
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.dmem_stall) begin
                        pc_we = 1'b0;
                    end else if (bus.redirect) begin
                        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
                        {if_id_fl, id_ex_fl} = 2'b11;
                    end else if (load_use) begin
                        {id_ex_we, ex_mem_we, mem_wb_we} = 3'b111;
                        id_ex_fl = 1'b1;
                    end else if (bus.imem_stall || bus.halt_id) begin
                        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
                        if_id_fl = 1'b1;
                    end else begin
                        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
                    end
                end
                DRAIN: begin
                    if (bus.dmem_stall) begin
                        pc_we = 1'b0;
                    end else if (bus.redirect) begin
                        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
                        {if_id_fl, id_ex_fl} = 2'b11;
                    end else begin
                        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
                        if_id_fl = 1'b1;
                    end
                end
                HALTED:  halted_o = 1'b1;
                default: halted_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (state_q == RUN || state_q == DRAIN) begin
            if (pc_we)                  stall_d = '0;
            else if (stall_q != CNT_SAT) stall_d = stall_q + CNT_ONE;
        end
        err_d = err_q | (state_q == ILLEGAL) | (stall_d >= CNT_LIM);
    end

    assign bus.pc_w_en     = pc_we;
    assign bus.if_id_w_en  = if_id_we;
    assign bus.id_ex_w_en  = id_ex_we;
    assign bus.ex_mem_w_en = ex_mem_we;
    assign bus.mem_wb_w_en = mem_wb_we;
    assign bus.if_id_flush = if_id_fl;
    assign bus.id_ex_flush = id_ex_fl;
    assign bus.halted      = halted_o;
    assign bus.stall_cnt   = stall_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RUN-state priority table plus hand-built
// sequences for stall counting, halt drain, watchdog and async reset.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REGW(3), .CNTW(4)) bus ();
    hazard_ctrl #(.REGW(3), .MAX_STALL(15), .CNTW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush
    typedef struct packed {
        logic       rd1, rd2, mr, redir, halt, imem, dmem;
        logic [2:0] rs, rt, rd;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic rd1, rd2, mr, redir, halt, imem, dmem,
                                input logic [2:0] rs, rt, rd, input logic [6:0] exp);
        vec_t v;
        v.rd1 = rd1; v.rd2 = rd2; v.mr = mr; v.redir = redir; v.halt = halt;
        v.imem = imem; v.dmem = dmem; v.rs = rs; v.rt = rt; v.rd = rd; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.pc_w_en, bus.if_id_w_en, bus.id_ex_w_en, bus.ex_mem_w_en,
                bus.mem_wb_w_en, bus.if_id_flush, bus.id_ex_flush};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs = 3'd0; bus.id_rt = 3'd0; bus.ex_rd = 3'd0;
        bus.id_read1 = 1'b0; bus.id_read2 = 1'b0; bus.ex_mem_read = 1'b0;
        bus.redirect = 1'b0; bus.halt_id = 1'b0;
        bus.imem_stall = 1'b0; bus.dmem_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle();
        //                 rd1 rd2 mr rdr hlt imm dmm rs    rt    rd    expected
        vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,3'd0,7'b1111100);
        vecs[1]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd3,3'd0,3'd3,7'b0011101);
        vecs[2]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'd1,3'd5,3'd5,7'b0011101);
        vecs[3]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd3,3'd3,3'd3,7'b1111100);
        vecs[4]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,3'd3,3'd3,7'b1111100);
        vecs[5]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,3'd4,3'd3,7'b1111100);
        vecs[6]  = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,3'd3,3'd0,3'd3,7'b1111111);
        vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0,3'd0,3'd0,7'b0111110);
        vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd0,3'd0,3'd0,7'b0000000);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,3'd0,3'd0,3'd0,7'b0000000);
        vecs[10] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,3'd6,3'd0,3'd6,7'b0011101);
        vecs[11] = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,3'd0,3'd0,3'd0,7'b1111111);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,3'd0,3'd0,3'd0,7'b0000000);

        // Reset state while held
        #1;
        check("reset_outs", 32'(outs()), 32'h03);
        check("reset_halted", 32'(bus.halted), 32'd0);
        check("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);

        // Priority table in RUN; halt_id only appears under a higher event
        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.id_read1 = vecs[i].rd1; bus.id_read2 = vecs[i].rd2;
            bus.ex_mem_read = vecs[i].mr; bus.redirect = vecs[i].redir;
            bus.halt_id = vecs[i].halt; bus.imem_stall = vecs[i].imem;
            bus.dmem_stall = vecs[i].dmem; bus.id_rs = vecs[i].rs;
            bus.id_rt = vecs[i].rt; bus.ex_rd = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            @(posedge clk); #1;
            check($sformatf("vec%0d_still_run", i), 32'(bus.halted), 32'd0);
            @(negedge clk);
        end

        // T1: single load-use bubble, stall counter 1 then 0
        do_reset();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd3; bus.id_rs = 3'd3; bus.id_read1 = 1'b1;
        #1;
        check("t1_bubble_outs", 32'(outs()), 32'b0011101);
        @(posedge clk); #1;
        check("t1_stall_cnt_1", 32'(bus.stall_cnt), 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("t1_resume_outs", 32'(outs()), 32'b1111100);
        @(posedge clk); #1;
        check("t1_stall_cnt_0", 32'(bus.stall_cnt), 32'd0);

        // T3: freeze with redirect held, redirect applied on first unfrozen cycle
        do_reset();
        bus.dmem_stall = 1'b1; bus.redirect = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("t3_freeze%0d_outs", c), 32'(outs()), 32'd0);
            @(negedge clk);
        end
        check("t3_stall_cnt_3", 32'(bus.stall_cnt), 32'd3);
        bus.dmem_stall = 1'b0;
        #1;
        check("t3_redirect_outs", 32'(outs()), 32'b1111111);
        @(posedge clk); #1;
        check("t3_stall_cnt_clr", 32'(bus.stall_cnt), 32'd0);
        @(negedge clk);

        // T4: halt drain extended by a 2-cycle dmem stall
        do_reset();
        bus.halt_id = 1'b1;
        #1;
        check("t4_halt_outs", 32'(outs()), 32'b0111110);
        @(negedge clk);
        bus.halt_id = 1'b0;
        #1;
        check("t4_drain0_outs", 32'(outs()), 32'b0111110);
        @(negedge clk);
        bus.dmem_stall = 1'b1;
        #1;
        check("t4_dmem0_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        check("t4_dmem1_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        bus.dmem_stall = 1'b0;
        #1;
        check("t4_drain1_outs", 32'(outs()), 32'b0111110);
        @(posedge clk); #1;
        check("t4_not_yet_halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        check("t4_drain2_outs", 32'(outs()), 32'b0111110);
        @(posedge clk); #1;
        check("t4_halted", 32'(bus.halted), 32'd1);
        check("t4_halted_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        bus.imem_stall = 1'b1; bus.redirect = 1'b1;
        #1;
        check("t4_halted_ignores_inputs", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        check("t4_stall_cnt_held", 32'(bus.stall_cnt), 32'd6);
        check("t4_still_halted", 32'(bus.halted), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t4_async_halted_clr", 32'(bus.halted), 32'd0);
        check("t4_async_outs", 32'(outs()), 32'h03);

        // Redirect during drain returns to RUN
        do_reset();
        bus.halt_id = 1'b1;
        @(negedge clk);
        bus.halt_id = 1'b0; bus.redirect = 1'b1;
        #1;
        check("drain_redirect_outs", 32'(outs()), 32'b1111111);
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        check("drain_redirect_run_outs", 32'(outs()), 32'b1111100);
        @(posedge clk); #1;
        check("drain_redirect_no_halt", 32'(bus.halted), 32'd0);

        // T5: watchdog at MAX_STALL, saturation, sticky err, async clear
        do_reset();
        bus.imem_stall = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("t5_cnt_14", 32'(bus.stall_cnt), 32'd14);
        check("t5_err_0", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        check("t5_cnt_15", 32'(bus.stall_cnt), 32'd15);
        check("t5_err_1", 32'(bus.err), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_cnt_sat", 32'(bus.stall_cnt), 32'd15);
        @(negedge clk);
        bus.imem_stall = 1'b0;
        @(posedge clk); #1;
        check("t5_cnt_clr", 32'(bus.stall_cnt), 32'd0);
        check("t5_err_sticky", 32'(bus.err), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_async_err_clr", 32'(bus.err), 32'd0);
        check("t5_async_halted", 32'(bus.halted), 32'd0);
        check("t5_async_cnt", 32'(bus.stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
